// File: rtl/rvv_cmdq_mpmp_pkg.sv
// Shared RVV definitions for the multi-push/multi-pop command queue:
// instruction type and default lane counts.
package rvv_cmdq_mpmp_pkg;

  typedef logic [31:0] INST_t;

  localparam int ISSUE_LANE  = 4;
  localparam int NUM_DE_INST = 2;

endpackage

// File: rtl/rvv_cmdq_mpmp_if.sv
// Issue-side push bus and decoder-side pop bus of the command queue.
interface rvv_cmdq_mpmp_if #(
  parameter int PUSH_LANE = rvv_cmdq_mpmp_pkg::ISSUE_LANE,
  parameter int POP_LANE  = rvv_cmdq_mpmp_pkg::NUM_DE_INST
);
  logic                                       [PUSH_LANE-1:0] push_valid;
  rvv_cmdq_mpmp_pkg::INST_t [PUSH_LANE-1:0]                   push_data;
  logic                                       [PUSH_LANE-1:0] push_ready;
  logic                                       [POP_LANE-1:0]  pop_valid;
  rvv_cmdq_mpmp_pkg::INST_t [POP_LANE-1:0]                    pop_data;
  logic                                       [POP_LANE-1:0]  pop_ready;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/rvv_cmdq_mpmp_chk.sv
// Simulation-only invariants of the command queue occupancy and transfer counts.
module rvv_cmdq_mpmp_chk #(
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int PUSH_LANE = 4,
  parameter int POP_LANE  = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic [CNT_W-1:0]     i_cnt,
  input logic [CNT_W-1:0]     i_free,
  input logic [CNT_W-1:0]     i_npush,
  input logic [CNT_W-1:0]     i_npop,
  input logic [PUSH_LANE-1:0] i_push_ready,
  input logic [POP_LANE-1:0]  i_pop_valid
);
  logic r_rst_seen;

  // remembers that a reset has been applied at least once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_seen <= 1'b1;
    end else begin
      r_rst_seen <= r_rst_seen;
    end
  end

  a_cnt_le_depth : assert property (@(posedge clk) disable iff (rst) i_cnt <= CNT_W'(DEPTH));
  a_push_le_free : assert property (@(posedge clk) disable iff (rst) i_npush <= i_free);
  a_pop_le_cnt   : assert property (@(posedge clk) disable iff (rst) i_npop <= i_cnt);
  a_no_x         : assert property (@(posedge clk) disable iff (rst || !r_rst_seen)
                                    !$isunknown({i_pop_valid, i_push_ready}));
endmodule

// File: rtl/rvv_cmdq_mpmp_prefix_cnt.sv
// Counts the leading run of set bits in a valid&ready vector; a clear bit
// ends the run so later set bits are ignored.
module rvv_cmdq_mpmp_prefix_cnt #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_cnt
);
  logic w_run;

  // leading-ones count
  always_comb begin
    o_cnt = '0;
    w_run = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_run && i_vec[i]) begin
        o_cnt = o_cnt + W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rvv_cmdq_mpmp.sv
// Multi-push/multi-pop RVV command queue: circular buffer of any depth,
// prefix-ordered push and pop lanes, flush/stop trap handling.
module rvv_cmdq_mpmp
  import rvv_cmdq_mpmp_pkg::*;
#(
  parameter int PUSH_LANE = ISSUE_LANE,
  parameter int POP_LANE  = NUM_DE_INST,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  rvv_cmdq_mpmp_if.slave   q_if,
  input  logic             i_stop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = PTR_W + CNT_W;
  localparam int PW    = $clog2(PUSH_LANE + 1);
  localparam int QW    = $clog2(POP_LANE + 1);

  INST_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_free;
  logic [PW-1:0]    w_npush;
  logic [QW-1:0]    w_npop;

  // Modular add for non-power-of-two depth; n never exceeds DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] n);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(n);
    if (sum >= SUM_W'(DEPTH)) begin
      ptr_add = PTR_W'(sum - SUM_W'(DEPTH));
    end else begin
      ptr_add = PTR_W'(sum);
    end
  endfunction

  // lane handshakes derived from registered count only
  always_comb begin
    w_free          = CNT_W'(DEPTH) - r_cnt;
    q_if.push_ready = '0;
    q_if.pop_valid  = '0;
    q_if.pop_data   = '0;
    for (int i = 0; i < PUSH_LANE; i++) begin
      q_if.push_ready[i] = !i_stop && !i_flush && (w_free > CNT_W'(i));
    end
    for (int j = 0; j < POP_LANE; j++) begin
      q_if.pop_valid[j] = !i_flush && (r_cnt > CNT_W'(j));
      q_if.pop_data[j]  = r_mem[ptr_add(r_rd_ptr, CNT_W'(j))];
    end
  end

  rvv_cmdq_mpmp_prefix_cnt #(.N(PUSH_LANE), .W(PW)) u_push_cnt (
    .i_vec (q_if.push_valid & q_if.push_ready),
    .o_cnt (w_npush)
  );

  rvv_cmdq_mpmp_prefix_cnt #(.N(POP_LANE), .W(QW)) u_pop_cnt (
    .i_vec (q_if.pop_valid & q_if.pop_ready),
    .o_cnt (w_npop)
  );

  // entry storage; not cleared by reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_LANE; k++) begin
      if (!rst && (PW'(k) < w_npush)) begin
        r_mem[ptr_add(r_wr_ptr, CNT_W'(k))] <= q_if.push_data[k];
      end
    end
  end

  // pointer and count update; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= ptr_add(r_wr_ptr, CNT_W'(w_npush));
      r_rd_ptr <= ptr_add(r_rd_ptr, CNT_W'(w_npop));
      r_cnt    <= r_cnt + CNT_W'(w_npush) - CNT_W'(w_npop);
    end
  end

  assign o_occupancy = r_cnt;

  rvv_cmdq_mpmp_chk #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .PUSH_LANE(PUSH_LANE), .POP_LANE(POP_LANE)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_cnt        (r_cnt),
    .i_free       (w_free),
    .i_npush      (CNT_W'(w_npush)),
    .i_npop       (CNT_W'(w_npop)),
    .i_push_ready (q_if.push_ready),
    .i_pop_valid  (q_if.pop_valid)
  );
endmodule

// File: tb/tb_rvv_cmdq_mpmp.sv
// Bench for rvv_cmdq_mpmp: DEPTH=8 and DEPTH=6 instances driven in lockstep and
// checked against a queue-based model plus a hand-derived vector table.
module tb_rvv_cmdq_mpmp;
  import rvv_cmdq_mpmp_pkg::*;

  localparam int PL = 4;
  localparam int QL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          stop_s;
  logic          flush_s;
  logic [PL-1:0] pv_s;
  INST_t [PL-1:0] pd_s;
  logic [QL-1:0] pr_s;
  logic [3:0]    occ8;
  logic [2:0]    occ6;

  rvv_cmdq_mpmp_if #(.PUSH_LANE(PL), .POP_LANE(QL)) if8 ();
  rvv_cmdq_mpmp_if #(.PUSH_LANE(PL), .POP_LANE(QL)) if6 ();

  assign if8.push_valid = pv_s;
  assign if8.push_data  = pd_s;
  assign if8.pop_ready  = pr_s;
  assign if6.push_valid = pv_s;
  assign if6.push_data  = pd_s;
  assign if6.pop_ready  = pr_s;

  rvv_cmdq_mpmp #(.PUSH_LANE(PL), .POP_LANE(QL), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .q_if(if8), .i_stop(stop_s), .i_flush(flush_s), .o_occupancy(occ8)
  );

  rvv_cmdq_mpmp #(.PUSH_LANE(PL), .POP_LANE(QL), .DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .q_if(if6), .i_stop(stop_s), .i_flush(flush_s), .o_occupancy(occ6)
  );

  INST_t m8[$];
  INST_t m6[$];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       s;
    logic       f;
    logic [3:0] pv;
    logic [1:0] pr;
    logic [3:0] er;
    logic [1:0] ev;
    int         eo;
  } vec_t;

  vec_t tbl[18];

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks one instance's outputs against the queue contents it should hold.
  task automatic check_q(input string tag, input int depth, input INST_t q[$],
                         input logic [PL-1:0] a_rdy, input logic [QL-1:0] a_pv,
                         input INST_t [QL-1:0] a_pd, input int a_occ);
    logic [PL-1:0] e_rdy;
    logic [QL-1:0] e_pv;
    for (int i = 0; i < PL; i++) e_rdy[i] = !stop_s && !flush_s && ((depth - q.size()) > i);
    for (int j = 0; j < QL; j++) e_pv[j] = !flush_s && (q.size() > j);
    cmp({tag, "_push_ready"}, a_rdy, e_rdy);
    cmp({tag, "_pop_valid"}, a_pv, e_pv);
    cmp({tag, "_occupancy"}, a_occ, q.size());
    for (int j = 0; j < QL; j++)
      if (e_pv[j]) cmp($sformatf("%s_pop_data%0d", tag, j), a_pd[j], q[j]);
  endtask

  // Next queue contents given the inputs currently driven.
  task automatic advance(input int depth, input INST_t qi[$], output INST_t qo[$]);
    int np, nq;
    qo = qi;
    if (rst || flush_s) begin
      qo = {};
    end else begin
      np = 0;
      while (np < PL && !stop_s && pv_s[np] && (depth - qi.size()) > np) np++;
      nq = 0;
      while (nq < QL && nq < qi.size() && pr_s[nq]) nq++;
      repeat (nq) void'(qo.pop_front());
      for (int k = 0; k < np; k++) qo.push_back(pd_s[k]);
    end
  endtask

  task automatic apply(input logic s, input logic f, input logic [3:0] pv, input logic [1:0] pr);
    stop_s  = s;
    flush_s = f;
    pv_s    = pv;
    pr_s    = pr;
    for (int k = 0; k < PL; k++) pd_s[k] = $urandom;
    #3;
    check_q("d8", 8, m8, if8.push_ready, if8.pop_valid, if8.pop_data, int'(occ8));
    check_q("d6", 6, m6, if6.push_ready, if6.pop_valid, if6.pop_data, int'(occ6));
  endtask

  task automatic tick();
    INST_t n8[$];
    INST_t n6[$];
    advance(8, m8, n8);
    advance(6, m6, n6);
    @(posedge clk);
    #1;
    m8 = n8;
    m6 = n6;
  endtask

  initial begin
    // stop, flush, push_valid, pop_ready -> DEPTH=8 push_ready, pop_valid, occupancy
    tbl[0]  = '{1'b0, 1'b0, 4'hF,    2'b00, 4'hF,    2'b00, 0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0,    2'b00, 4'hF,    2'b11, 4};
    tbl[2]  = '{1'b0, 1'b0, 4'h3,    2'b00, 4'hF,    2'b11, 4};
    tbl[3]  = '{1'b0, 1'b0, 4'hF,    2'b00, 4'b0011, 2'b11, 6};
    tbl[4]  = '{1'b0, 1'b0, 4'hF,    2'b11, 4'h0,    2'b11, 8};
    tbl[5]  = '{1'b0, 1'b0, 4'h0,    2'b10, 4'b0011, 2'b11, 6};
    tbl[6]  = '{1'b0, 1'b0, 4'h0,    2'b01, 4'b0011, 2'b11, 6};
    tbl[7]  = '{1'b1, 1'b0, 4'hF,    2'b11, 4'h0,    2'b11, 5};
    tbl[8]  = '{1'b1, 1'b0, 4'hF,    2'b11, 4'h0,    2'b11, 3};
    tbl[9]  = '{1'b1, 1'b0, 4'h0,    2'b11, 4'h0,    2'b01, 1};
    tbl[10] = '{1'b1, 1'b0, 4'h0,    2'b11, 4'h0,    2'b00, 0};
    tbl[11] = '{1'b0, 1'b0, 4'b1101, 2'b00, 4'hF,    2'b00, 0};
    tbl[12] = '{1'b0, 1'b0, 4'hF,    2'b00, 4'hF,    2'b01, 1};
    tbl[13] = '{1'b0, 1'b0, 4'h3,    2'b00, 4'b0111, 2'b11, 5};
    tbl[14] = '{1'b0, 1'b1, 4'hF,    2'b11, 4'h0,    2'b00, 7};
    tbl[15] = '{1'b0, 1'b0, 4'h3,    2'b00, 4'hF,    2'b00, 0};
    tbl[16] = '{1'b0, 1'b0, 4'h0,    2'b11, 4'hF,    2'b11, 2};
    tbl[17] = '{1'b0, 1'b0, 4'h0,    2'b00, 4'hF,    2'b00, 0};

    rst = 1'b1; stop_s = 1'b0; flush_s = 1'b0; pv_s = '0; pr_s = '0; pd_s = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m8 = {};
    m6 = {};

    for (int t = 0; t < 18; t++) begin
      apply(tbl[t].s, tbl[t].f, tbl[t].pv, tbl[t].pr);
      cmp($sformatf("tbl%0d_push_ready", t), if8.push_ready, tbl[t].er);
      cmp($sformatf("tbl%0d_pop_valid", t), if8.pop_valid, tbl[t].ev);
      cmp($sformatf("tbl%0d_occupancy", t), occ8, tbl[t].eo);
      tick();
    end

    // sustained 4-in/2-out traffic wraps the DEPTH=6 pointers several times
    for (int c = 0; c < 20; c++) begin
      apply(1'b0, 1'b0, 4'hF, 2'b11);
      cmp("d6_occ_bound", occ6 <= 3'd6, 1);
      tick();
    end

    // reset in the middle of traffic
    apply(1'b0, 1'b0, 4'h7, 2'b00);
    tick();
    rst = 1'b1;
    apply(1'b0, 1'b0, 4'hF, 2'b11);
    tick();
    rst = 1'b0;
    apply(1'b0, 1'b0, 4'h0, 2'b00);
    cmp("rst_mid_occ8", occ8, 0);
    cmp("rst_mid_occ6", occ6, 0);
    tick();

    // randomized traffic; push_valid biased toward contiguous prefixes
    for (int c = 0; c < 400; c++) begin
      logic [3:0] pv;
      pv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'((5'd1 << $urandom_range(0, 4)) - 5'd1);
      apply($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, pv, 2'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rvv_cmdq_mpmp.md
Name: rvv_cmdq_mpmp

Overview:
Parametrised multi-push/multi-pop command queue, the next generation of the RVV command queue. It sits between the RVS issue interface and the RVV decoder. Each cycle it accepts an in-order prefix of up to PUSH_LANE vector instructions and presents up to POP_LANE oldest entries to the decoder. It adds an occupancy output, non-power-of-two depth, and defined stop/flush interaction with same-cycle traffic.

Parameters:
PUSH_LANE, 4, number of RVS issue lanes (ISSUE_LANE).
POP_LANE, 2, number of decoder lanes (NUM_DE_INST).
DEPTH, 8, queue entries; any integer with DEPTH >= max(PUSH_LANE, POP_LANE); need not be a power of two.
CNT_W, $clog2(DEPTH+1), occupancy width (derived).

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
push_valid  input  [PUSH_LANE]  per-lane instruction valid from RVS
push_data  input  [PUSH_LANE] x INST_t  instructions; lane 0 is the oldest
push_ready  output  [PUSH_LANE]  per-lane ready to RVS
pop_valid  output  [POP_LANE]  per-lane entry valid to decoder
pop_data  output  [POP_LANE] x INST_t  queued instructions; lane 0 is the oldest
pop_ready  input  [POP_LANE]  per-lane decoder ready
stop  input  1  trap stop: blocks new pushes
flush  input  1  trap flush: discards all entries
occupancy  output  CNT_W  registered entry count

Behaviour:
- State:
  - mem[DEPTH] of INST_t; rd_ptr and wr_ptr in [0, DEPTH-1]; cnt in [0, DEPTH].
  - No explicit FSM; queue state is fully described by (rd_ptr, cnt).
- Reset (rst=1 at a clk edge): rd_ptr=wr_ptr=cnt=0. mem is not cleared.
  - Resulting outputs: pop_valid all 0, occupancy=0, push_ready[i]=1 for all i (when stop=0 and flush=0).
- Free space: free = DEPTH - cnt, from registered cnt only. Same-cycle pops do not add space.
- push_ready[i] = !stop && !flush && (free > i). Combinational from registers and stop/flush. Independent of push_valid.
- Push accept:
  - Lane i is accepted iff push_ready[i] && push_valid[j] for all j <= i. A valid gap blocks all higher lanes.
  - npush = number of accepted lanes, in 0..PUSH_LANE.
  - Accepted lane k is written to mem[(wr_ptr + k) mod DEPTH].
- pop_valid[j] = !flush && (cnt > j).
- pop_data[j] = mem[(rd_ptr + j) mod DEPTH]. When pop_valid[j]=0, pop_data[j] is don't-care.
- Pop consume:
  - Lane j is consumed iff pop_valid[j] && pop_ready[j] && lane j-1 was consumed (lane 0 has no predecessor condition).
  - npop = number of consumed lanes.
  - The decoder is permitted to assert ready on a non-prefix set; only the prefix counts.
- Update at each clk edge when rst=0 and flush=0:
  - wr_ptr += npush (mod DEPTH)
  - rd_ptr += npop (mod DEPTH)
  - cnt += npush - npop
- Latency: an entry pushed in cycle N is visible at pop_valid in cycle N+1. There is no bypass.
- Simultaneous push and pop: both are applied. At full, a pop does not allow a same-cycle push.
- Wrap-around:
  - Pointer adds are modular for any DEPTH, computed as sum >= DEPTH ? sum - DEPTH : sum.
  - No power-of-two masking is used.
- Flush:
  - In the flush cycle, push_ready=0 and pop_valid=0, so no transfers occur.
  - Next edge: rd_ptr=wr_ptr=cnt=0.
  - Flush has priority over stop, push and pop.
- Stop: push_ready forced to 0. Pops continue normally and the queue drains. Stop has no effect on state.
- Reset asserted mid-operation: same as flush, and overrides everything.
- occupancy = cnt (registered).
- Assertions (sim only):
  - cnt <= DEPTH.
  - npush <= free.
  - npop <= cnt.
  - No X on pop_valid or push_ready after reset.

Decomposition:
- Shared RVV package (rvv.svh):
  - INST_t.
  - ISSUE_LANE and NUM_DE_INST, used as the PUSH_LANE and POP_LANE defaults.
- Sub-module rvv_cmdq_prefix_cnt, instantiated twice:
  - Input: valid/ready vector of width N.
  - Output: count of the leading all-true prefix.
  - Used once for npush and once for npop.
- Modular pointer add is a local function.

Test Plan:
- Reset then push 4 valid lanes with DEPTH=8 -> all push_ready=1, npush=4. Next cycle occupancy=4, pop_valid=2'b11, pop_data[0]=lane0 instruction.
- Push with cnt=6, DEPTH=8, 4 valid lanes -> push_ready=4'b0011, only lanes 0-1 stored, occupancy=8, all push_ready=0 next cycle.
- push_valid=4'b1101 on an empty queue -> only lane 0 accepted, occupancy=1.
- DEPTH=6, repeated 4-push/2-pop traffic for 20 cycles -> data pops out in exact push order across pointer wrap, occupancy never exceeds 6.
- stop=1 with cnt=5 and pop_ready=2'b11 -> push_ready=0, occupancy goes 5,3,1,0, pops remain in order.
- flush=1 with cnt=7 while push_valid=4'hF and pop_ready=2'b11 -> no transfer that cycle, occupancy=0 next cycle, subsequent push round-trips correctly.
